// File: rtl/clip_recorder_pkg.sv
// Shared types and helpers for the clip recorder controller: FSM state
// encoding, derived-width helpers and the one-hot clip decoder.
package clip_recorder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REC   = 2'd1,
    PLAY  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Upper bound on the one-hot decoder width; callers size-cast the result.
  localparam int MAX_CLIPS = 32;

  function automatic int clip_w_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int addr_w_f(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

  function automatic logic [MAX_CLIPS-1:0] onehot(input int idx);
    logic [MAX_CLIPS-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/clip_recorder_ctrl_edge.sv
// Registered rising-edge detector for the debounced record/play levels.
module edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic din_q;
  logic din_d;

  always_comb din_d = din;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) din_q <= 1'b0;
    else        din_q <= din_d;
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/clip_recorder_ctrl.sv
// Record/playback controller for NUM_CLIPS clips sharing one memory bus.
// Optional macro LOOP_PLAY_EN: holding play at the end of a pass restarts it.
module clip_recorder_ctrl
  import clip_recorder_pkg::*;
#(
  parameter int NUM_CLIPS = 2,
  parameter int SAMPLE_W  = 16,
  parameter int DEPTH     = 131072,
  parameter int ADDR_W    = addr_w_f(DEPTH),
  parameter int CLIP_W    = clip_w_f(NUM_CLIPS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic [CLIP_W-1:0]    clip_sel,
  input  logic                 record,
  input  logic                 play,
  input  logic [SAMPLE_W-1:0]  sample_in,
  output logic [SAMPLE_W-1:0]  sample_out,
  output logic                 sample_valid,
  output logic [NUM_CLIPS-1:0] mem_sel,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [SAMPLE_W-1:0]  mem_wdata,
  input  logic [SAMPLE_W-1:0]  mem_rdata,
  output logic                 recording,
  output logic                 playing,
  output logic [CLIP_W-1:0]    active_clip,
  output state_e               dbg_state
);

  localparam logic [ADDR_W:0] PTR_ONE    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] LAST_IDX   = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [CLIP_W:0] CLIP_LIMIT = (CLIP_W+1)'(NUM_CLIPS);

  state_e                state_q, state_d;
  logic [CLIP_W-1:0]     active_q, active_d;
  logic [ADDR_W:0]       ptr_q, ptr_d;
  logic [ADDR_W:0]       len_q [NUM_CLIPS];
  logic [ADDR_W:0]       len_d [NUM_CLIPS];
  logic [SAMPLE_W-1:0]   sample_out_q, sample_out_d;
  logic                  valid_q, valid_d;
  logic                  rd_pend_q, rd_pend_d;

  logic                  rec_rise;
  logic                  play_rise;
  logic                  sel_ok;
  logic [ADDR_W:0]       sel_len;
  logic [NUM_CLIPS-1:0]  active_onehot;

  edge_detect u_rec_edge (
    .clock (clock),
    .reset (reset),
    .din   (record),
    .rise  (rec_rise)
  );

  edge_detect u_play_edge (
    .clock (clock),
    .reset (reset),
    .din   (play),
    .rise  (play_rise)
  );

  always_comb begin
    sel_ok  = ({1'b0, clip_sel} < CLIP_LIMIT);
    sel_len = '0;
    for (int i = 0; i < NUM_CLIPS; i++) begin
      if ({1'b0, clip_sel} == (CLIP_W+1)'(i)) sel_len = len_q[i];
    end
    active_onehot = NUM_CLIPS'(onehot(int'(active_q)));
  end

  always_comb begin
    state_d      = state_q;
    active_d     = active_q;
    ptr_d        = ptr_q;
    len_d        = len_q;
    sample_out_d = sample_out_q;
    valid_d      = 1'b0;
    rd_pend_d    = 1'b0;
    mem_sel      = '0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;

    // Read data arrives the cycle after the read was issued, whatever the state.
    if (rd_pend_q) begin
      sample_out_d = mem_rdata;
      valid_d      = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (sample_tick) sample_out_d = '0;
        if (rec_rise && sel_ok) begin
          active_d = clip_sel;
          ptr_d    = '0;
          state_d  = REC;
        end else if (play_rise && sel_ok && (sel_len != '0)) begin
          active_d = clip_sel;
          ptr_d    = '0;
          state_d  = PLAY;
        end
      end

      REC: begin
        // Releasing record wins over a coincident tick: that sample is dropped.
        if (!record) begin
          len_d[active_q] = ptr_q;
          state_d         = IDLE;
        end else if (sample_tick) begin
          mem_sel   = active_onehot;
          mem_we    = 1'b1;
          mem_addr  = ptr_q[ADDR_W-1:0];
          mem_wdata = sample_in;
          ptr_d     = ptr_q + PTR_ONE;
          if (ptr_q == LAST_IDX) begin
            len_d[active_q] = ptr_q + PTR_ONE;
            state_d         = IDLE;
          end
        end
      end

      PLAY: begin
        if (sample_tick) begin
          mem_sel   = active_onehot;
          mem_addr  = ptr_q[ADDR_W-1:0];
          rd_pend_d = 1'b1;
          ptr_d     = ptr_q + PTR_ONE;
          if (ptr_q == (len_q[active_q] - PTR_ONE)) begin
`ifdef LOOP_PLAY_EN
            if (play) ptr_d = '0;
            else      state_d = DRAIN;
`else
            state_d = DRAIN;
`endif
          end
        end
      end

      DRAIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      active_q     <= '0;
      ptr_q        <= '0;
      sample_out_q <= '0;
      valid_q      <= 1'b0;
      rd_pend_q    <= 1'b0;
      for (int i = 0; i < NUM_CLIPS; i++) len_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      ptr_q        <= ptr_d;
      sample_out_q <= sample_out_d;
      valid_q      <= valid_d;
      rd_pend_q    <= rd_pend_d;
      len_q        <= len_d;
    end
  end

  assign sample_out   = sample_out_q;
  assign sample_valid = valid_q;
  assign recording    = (state_q == REC);
  assign playing      = (state_q == PLAY) || (state_q == DRAIN);
  assign active_clip  = active_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_clip_recorder_ctrl.sv
// Directed bench for clip_recorder_ctrl with NUM_CLIPS=2, DEPTH=8 and a
// behavioural pair of clip memories with one-cycle read latency.
module tb_clip_recorder_ctrl;
  import clip_recorder_pkg::*;

  localparam int NC = 2;
  localparam int SW = 16;
  localparam int DP = 8;
  localparam int AW = 3;
  localparam int CW = 1;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          sample_tick = 1'b0;
  logic [CW-1:0] clip_sel = '0;
  logic          record = 1'b0;
  logic          play = 1'b0;
  logic [SW-1:0] sample_in = '0;
  logic [SW-1:0] sample_out;
  logic          sample_valid;
  logic [NC-1:0] mem_sel;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [SW-1:0] mem_wdata;
  logic [SW-1:0] mem_rdata = '0;
  logic          recording;
  logic          playing;
  logic [CW-1:0] active_clip;
  state_e        dbg_state;

  int checks = 0;
  int errors = 0;

  logic [SW-1:0] bram0 [DP];
  logic [SW-1:0] bram1 [DP];
  logic [SW-1:0] vals [3] = '{16'h0011, 16'h0022, 16'h0033};

  clip_recorder_ctrl #(
    .NUM_CLIPS (NC),
    .SAMPLE_W  (SW),
    .DEPTH     (DP)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .clip_sel     (clip_sel),
    .record       (record),
    .play         (play),
    .sample_in    (sample_in),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .mem_sel      (mem_sel),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .recording    (recording),
    .playing      (playing),
    .active_clip  (active_clip),
    .dbg_state    (dbg_state)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_sel == 2'b01) begin
      if (mem_we) bram0[mem_addr] <= mem_wdata;
      mem_rdata <= bram0[mem_addr];
    end else if (mem_sel == 2'b10) begin
      if (mem_we) bram1[mem_addr] <= mem_wdata;
      mem_rdata <= bram1[mem_addr];
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step(input logic tk);
    @(negedge clock);
    sample_tick = tk;
    #1;
  endtask

  task automatic test_reset();
    step(0);
    step(0);
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", dbg_state, IDLE); end
    checks++; if ({sample_out, sample_valid, mem_sel, mem_we, mem_addr, mem_wdata, recording, playing, active_clip} !== '0) begin
      errors++; $display("FAIL reset_outputs got out=%h v=%b sel=%b we=%b a=%h wd=%h rec=%b pl=%b ac=%h exp all 0",
                         sample_out, sample_valid, mem_sel, mem_we, mem_addr, mem_wdata, recording, playing, active_clip);
    end
    step(0);
    reset = 1'b1;
    step(0);
  endtask

  task automatic test_empty_and_simul();
    step(0); clip_sel = 1'b1; play = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      checks++; if (dbg_state !== IDLE || mem_sel !== 2'b00) begin
        errors++; $display("FAIL empty_play[%0d] got state=%0d sel=%b exp IDLE sel=00", i, dbg_state, mem_sel);
      end
    end
    play = 1'b0;
    step(0); clip_sel = 1'b0; record = 1'b1; play = 1'b1;
    step(0);
    checks++; if (dbg_state !== REC || recording !== 1'b1 || playing !== 1'b0) begin
      errors++; $display("FAIL simul_rise got state=%0d rec=%b pl=%b exp REC 1 0", dbg_state, recording, playing);
    end
    record = 1'b0; play = 1'b0;
    step(0);
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL simul_exit got %0d exp %0d", dbg_state, IDLE); end
  endtask

  task automatic test_record_clip0();
    step(0); clip_sel = 1'b0; record = 1'b1;
    step(0); clip_sel = 1'b1;
    checks++; if (dbg_state !== REC || recording !== 1'b1 || active_clip !== 1'b0) begin
      errors++; $display("FAIL rec0_start got state=%0d rec=%b ac=%h exp REC 1 0", dbg_state, recording, active_clip);
    end
    for (int i = 0; i < 3; i++) begin
      step(1); sample_in = vals[i]; #1;
      checks++; if (mem_sel !== 2'b01 || mem_we !== 1'b1 || mem_addr !== AW'(i) || mem_wdata !== vals[i]) begin
        errors++; $display("FAIL rec0_write[%0d] got sel=%b we=%b a=%h wd=%h exp 01 1 %h %h", i, mem_sel, mem_we, mem_addr, mem_wdata, AW'(i), vals[i]);
      end
      step(0);
      checks++; if (mem_we !== 1'b0 || mem_sel !== 2'b00 || mem_addr !== '0) begin
        errors++; $display("FAIL rec0_idle_bus[%0d] got we=%b sel=%b a=%h exp 0 00 0", i, mem_we, mem_sel, mem_addr);
      end
    end
    step(1); record = 1'b0; sample_in = 16'hdead; #1;
    checks++; if (mem_we !== 1'b0 || mem_sel !== 2'b00) begin
      errors++; $display("FAIL rec0_release_write got we=%b sel=%b exp 0 00", mem_we, mem_sel);
    end
    step(0);
    checks++; if (dbg_state !== IDLE || recording !== 1'b0 || active_clip !== 1'b0) begin
      errors++; $display("FAIL rec0_end got state=%0d rec=%b ac=%h exp IDLE 0 0", dbg_state, recording, active_clip);
    end
  endtask

  task automatic test_play_clip0();
    logic [SW-1:0] prev;
    prev = '0;
    step(0); clip_sel = 1'b0; play = 1'b1;
    step(0); play = 1'b0; clip_sel = 1'b1;
    checks++; if (dbg_state !== PLAY || playing !== 1'b1 || active_clip !== 1'b0) begin
      errors++; $display("FAIL play0_start got state=%0d pl=%b ac=%h exp PLAY 1 0", dbg_state, playing, active_clip);
    end
    for (int i = 0; i < 3; i++) begin
      step(1);
      checks++; if (mem_sel !== 2'b01 || mem_we !== 1'b0 || mem_addr !== AW'(i)) begin
        errors++; $display("FAIL play0_read[%0d] got sel=%b we=%b a=%h exp 01 0 %h", i, mem_sel, mem_we, mem_addr, AW'(i));
      end
      step(0);
      checks++; if (sample_valid !== 1'b0 || sample_out !== prev) begin
        errors++; $display("FAIL play0_hold[%0d] got v=%b out=%h exp 0 %h", i, sample_valid, sample_out, prev);
      end
      if (i == 2) begin
        checks++; if (dbg_state !== DRAIN || playing !== 1'b1) begin
          errors++; $display("FAIL play0_drain got state=%0d pl=%b exp DRAIN 1", dbg_state, playing);
        end
      end
      step(0);
      checks++; if (sample_valid !== 1'b1 || sample_out !== vals[i]) begin
        errors++; $display("FAIL play0_sample[%0d] got v=%b out=%h exp 1 %h", i, sample_valid, sample_out, vals[i]);
      end
      prev = vals[i];
    end
    checks++; if (dbg_state !== IDLE || playing !== 1'b0) begin
      errors++; $display("FAIL play0_end got state=%0d pl=%b exp IDLE 0", dbg_state, playing);
    end
    step(0);
    checks++; if (sample_out !== 16'h0033 || sample_valid !== 1'b0) begin
      errors++; $display("FAIL play0_idle_hold got out=%h v=%b exp 0033 0", sample_out, sample_valid);
    end
    step(1);
    step(0);
    checks++; if (sample_out !== 16'h0000) begin
      errors++; $display("FAIL play0_idle_clear got %h exp 0000", sample_out);
    end
  endtask

  task automatic test_record_full_clip1();
    int nw;
    nw = 0;
    step(0); clip_sel = 1'b1; record = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1); sample_in = SW'(16'h0100 + i); #1;
      if (mem_we === 1'b1) begin
        checks++; if (mem_sel !== 2'b10 || mem_addr !== AW'(nw) || mem_wdata !== SW'(16'h0100 + nw)) begin
          errors++; $display("FAIL rec1_write[%0d] got sel=%b a=%h wd=%h exp 10 %h %h", nw, mem_sel, mem_addr, mem_wdata, AW'(nw), SW'(16'h0100 + nw));
        end
        nw++;
      end
    end
    checks++; if (nw != 8) begin errors++; $display("FAIL rec1_count got %0d exp 8", nw); end
    checks++; if (dbg_state !== IDLE || recording !== 1'b0) begin
      errors++; $display("FAIL rec1_autostop got state=%0d rec=%b exp IDLE 0", dbg_state, recording);
    end
    record = 1'b0;
    step(0);
  endtask

  task automatic test_clip0_kept();
    int nr;
    nr = 0;
    step(0); clip_sel = 1'b0; play = 1'b1;
    step(0); play = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (mem_sel !== 2'b00) nr++;
    end
    checks++; if (nr != 3) begin errors++; $display("FAIL clip0_len_kept got %0d reads exp 3", nr); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL clip0_play_done got %0d exp %0d", dbg_state, IDLE); end
  endtask

  task automatic test_reset_mid_play();
    step(0); clip_sel = 1'b1; play = 1'b1;
    step(0); play = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      checks++; if (mem_sel !== 2'b10 || mem_addr !== AW'(i)) begin
        errors++; $display("FAIL play1_read[%0d] got sel=%b a=%h exp 10 %h", i, mem_sel, mem_addr, AW'(i));
      end
      if (i < 4) step(0);
    end
    checks++; if (sample_out !== 16'h0103 || active_clip !== 1'b1) begin
      errors++; $display("FAIL play1_before_reset got out=%h ac=%h exp 0103 1", sample_out, active_clip);
    end
    reset = 1'b0; #1;
    checks++; if ({sample_out, sample_valid, mem_sel, mem_we, mem_addr, mem_wdata, recording, playing, active_clip} !== '0) begin
      errors++; $display("FAIL midreset_outputs got out=%h v=%b sel=%b we=%b a=%h wd=%h rec=%b pl=%b ac=%h exp all 0",
                         sample_out, sample_valid, mem_sel, mem_we, mem_addr, mem_wdata, recording, playing, active_clip);
    end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL midreset_state got %0d exp %0d", dbg_state, IDLE); end
    step(0);
    reset = 1'b1;
    step(0); clip_sel = 1'b1; play = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      checks++; if (dbg_state !== IDLE || mem_sel !== 2'b00) begin
        errors++; $display("FAIL play1_after_reset[%0d] got state=%0d sel=%b exp IDLE 00", i, dbg_state, mem_sel);
      end
    end
    play = 1'b0;
    step(0);
  endtask

`ifdef LOOP_PLAY_EN
  task automatic test_loop();
    logic [AW-1:0] exp_a [6] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2};
    step(0); clip_sel = 1'b0; record = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1); sample_in = vals[i];
    end
    step(0); record = 1'b0;
    step(0); play = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(1);
      checks++; if (mem_sel !== 2'b01 || mem_addr !== exp_a[k]) begin
        errors++; $display("FAIL loop_read[%0d] got sel=%b a=%h exp 01 %h", k, mem_sel, mem_addr, exp_a[k]);
      end
      if (k == 3) play = 1'b0;
    end
    step(1);
    checks++; if (dbg_state !== DRAIN || mem_sel !== 2'b00) begin
      errors++; $display("FAIL loop_drain got state=%0d sel=%b exp DRAIN 00", dbg_state, mem_sel);
    end
    step(0);
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL loop_end got %0d exp %0d", dbg_state, IDLE); end
  endtask
`endif

  initial begin
    test_reset();
    test_empty_and_simul();
    test_record_clip0();
    test_play_clip0();
    test_record_full_clip1();
    test_clip0_kept();
    test_reset_mid_play();
`ifdef LOOP_PLAY_EN
    test_loop();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clip_recorder_ctrl.md
Name: clip_recorder_ctrl

Overview:
- Parametrised record/playback controller for the audio clip recorder; generalises the fixed two-clip arrangement to NUM_CLIPS clips.
- Owns the record/play FSM, per-clip write/read address counters and per-clip recorded-length registers.
- Drives a shared single-port memory interface with a one-hot clip select, one BRAM per clip.
- Sits between the sample-rate strobe and the input/output sample paths (top level) and the clip BRAMs.

Parameters:
- NUM_CLIPS, 2, number of independent clips/BRAMs (>=1)
- SAMPLE_W, 16, sample width in bits
- DEPTH, 131072, samples per clip
- ADDR_W, $clog2(DEPTH), memory address width (derived)
- CLIP_W, $clog2(NUM_CLIPS) min 1, clip index width (derived)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- sample_tick  in  1  one-cycle strobe at the sample rate
- clip_sel  in  CLIP_W  clip chosen by user
- record  in  1  level, debounced; rising edge starts, low stops
- play  in  1  level, debounced; rising edge starts playback
- sample_in  in  SAMPLE_W  input audio sample
- sample_out  out  SAMPLE_W  playback sample, held between updates
- sample_valid  out  1  one-cycle pulse when sample_out updates
- mem_sel  out  NUM_CLIPS  one-hot BRAM enable
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  address
- mem_wdata  out  SAMPLE_W  write data
- mem_rdata  in  SAMPLE_W  read data, valid 1 cycle after a read
- recording  out  1  FSM in REC
- playing  out  1  FSM in PLAY or DRAIN
- active_clip  out  CLIP_W  clip latched at start

Behaviour:
- Reset (async, active-low):
  - State IDLE; all outputs 0.
  - All clip lengths and pointers cleared.
  - Reset mid-operation abandons the clip; its length reads as 0.
- Edge detection: record and play are registered internally; a start is a 0->1 transition.
- States: IDLE, REC, PLAY, DRAIN.
- IDLE:
  - Record rise: latch clip_sel into active_clip, ptr=0, go to REC.
  - Play rise with length[clip_sel]>0: latch clip_sel, ptr=0, go to PLAY.
  - Play rise with length 0: ignored.
  - Record and play rise in the same cycle: record wins.
  - clip_sel >= NUM_CLIPS: start ignored.
- REC:
  - On each sample_tick: mem_sel=onehot(active_clip), mem_we=1, mem_addr=ptr, mem_wdata=sample_in for that one cycle; ptr++.
  - Exit to IDLE when record is low, or when the write at DEPTH-1 completes (full).
  - On exit, length[active_clip]=number of samples written (0..DEPTH).
  - A record low and a tick in the same cycle: no write; exit.
  - Re-recording a clip overwrites it; the new length replaces the old.
- PLAY:
  - On each sample_tick: mem_sel=onehot, mem_we=0, mem_addr=ptr, ptr++.
  - Next cycle: sample_out<=mem_rdata and sample_valid=1. Latency from tick to sample_out is 2 clocks.
  - After issuing the read at ptr=length-1, go to DRAIN.
- DRAIN: capture the final sample and pulse sample_valid, then go to IDLE.
- IDLE output: sample_out cleared to 0 on the first sample_tick seen in IDLE.
- Bus idle: outside an issuing cycle, mem_sel=0, mem_we=0, mem_addr/mem_wdata=0.
- Ignored inputs:
  - Play/record rises outside IDLE are ignored; play level is ignored during PLAY.
  - clip_sel changes after start have no effect.
- Pointer: ADDR_W+1 bits wide so the value DEPTH is representable; no wrap.

Optional Feature:
- Macro LOOP_PLAY_EN.
- Defined: at the end of PLAY, if play is still high, ptr returns to 0 and playback continues seamlessly. The read of index 0 is issued on the tick after the read of length-1; DRAIN is skipped. Releasing play finishes the current pass.
- Undefined: single-shot playback as above; play level is ignored after start.

Decomposition:
- Package clip_recorder_pkg:
  - state enum (IDLE, REC, PLAY, DRAIN)
  - CLIP_W/ADDR_W helper functions
  - onehot function
- Sub-module edge_detect (registered rising-edge detector), instantiated for record and play.
- Length array and FSM stay in clip_recorder_ctrl.

Test Plan:
- NUM_CLIPS=2, DEPTH=8. Record clip0, record held for 3 ticks with sample_in=0x0011,0x0022,0x0033, then released -> writes at addr 0,1,2 with mem_sel=01; length0=3; recording falls.
- Play clip0 -> reads at addr 0,1,2; sample_out=0x0011,0x0022,0x0033, each 2 clocks after its tick with a sample_valid pulse; DRAIN then IDLE; sample_out=0 on the next tick.
- Record clip1 with record held for 10 ticks -> exactly 8 writes, mem_sel=10, auto-stop after addr 7, length1=8; clip0 length is unchanged.
- Play an empty clip after reset -> stays IDLE, no mem_sel activity. Record and play rising in the same cycle -> REC.
- Drop reset during PLAY of clip1 at addr 4 -> all outputs 0 immediately; subsequent play of clip1 is ignored (length 0).
- With LOOP_PLAY_EN and play held, play a 3-sample clip -> address sequence 0,1,2,0,1,2 with no gap tick; releasing play ends after addr 2.
